// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side end of the MIPS core's load/store port. It accepts one word
// request at a time over a valid/ready handshake and holds it for LATENCY
// cycles. It then performs the store or the load against an internal word
// array, and returns read data plus an error flag over a second valid/ready
// handshake.
//
// Parameters
//   ADDR_WIDTH  word-address width; the array holds 2^ADDR_WIDTH 32-bit words
//   LATENCY     cycles from request acceptance to response valid (1..15)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   req_valid   request present
//   req_ready   responder can accept a request
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   req_be      byte enables, bit i selects bits 8i+7:8i
//   resp_valid  response present
//   resp_ready  requester takes the response
//   resp_rdata  load data, 0 for stores and errors
//   resp_err    request was misaligned or out of range
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem [DEPTH];

  logic                  access_s;
  logic                  addr_err_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [31:0]           rd_word_s;

  // A request is rejected when it is not word aligned or lies beyond the array.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_WIDTH+2] != {(30-ADDR_WIDTH){1'b0}});
  endfunction

  assign access_s   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign addr_err_s = addr_bad(addr_q);
  assign word_idx_s = addr_q[ADDR_WIDTH+1:2];
  assign rd_word_s  = mem[word_idx_s];
  // Gating with reset means a store caught in WAIT by reset never lands.
  assign mem_we_s   = access_s && we_q && !addr_err_s && !reset;

  // The registered ready is held high across reset so it can be up in the
  // first cycle after release; masking with reset keeps it low during reset.
  assign req_ready  = req_ready_q && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Next-state and next-output computation for the request/response FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = req_be;
          cnt_d       = CNT_LOAD;
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = addr_err_s;
          // Loads return the whole word whatever the byte enables say.
          if (!we_q && !addr_err_s) begin
            resp_rdata_d = rd_word_s;
          end else begin
            resp_rdata_d = 32'h0000_0000;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0000_0000;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d      = S_IDLE;
        cnt_d        = 4'd0;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  // FSM state, latched request and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      be_q         <= 4'b0000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Word array: byte-masked store; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[word_idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder: a table of load/store vectors against a
// LATENCY=2 instance, hand-written sequences for backpressure and reset in
// WAIT, and a back-to-back throughput run on a LATENCY=1 instance.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk;
  logic reset;

  // LATENCY=2 instance signals
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  // LATENCY=1 instance signals
  logic        r1_req_valid, r1_req_ready, r1_req_we;
  logic [31:0] r1_req_addr, r1_req_wdata;
  logic [3:0]  r1_req_be;
  logic        r1_resp_valid, r1_resp_ready, r1_resp_err;
  logic [31:0] r1_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_we(r1_req_we),
    .req_addr(r1_req_addr), .req_wdata(r1_req_wdata), .req_be(r1_req_be),
    .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready),
    .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Wait (bounded) for resp_valid; called on the negedge after the accept edge.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk1("resp_timeout", lat < 20, 1'b1);
  endtask

  // One full transaction on the LATENCY=2 instance; returns response and latency.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("req_ready_timeout", n < 20, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    wait_resp(lat);
    rd = resp_rdata;
    er = resp_err;
    chk1("req_ready_in_resp", req_ready, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk1("req_ready_after_consume", req_ready, 1'b1);
    chk1("resp_valid_after_consume", resp_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          last_acc;
    int          n_acc;
    int          n_rv;
    logic        acc;
    logic        rv;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDE22_BE44, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0012, 32'hCAFE_BABE, 4'b1111, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDE22_BE44, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'b1111, 32'h0BAD_F00D, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b1111, 32'h1234_5678, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0012, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b1};

    reset         = 1'b1;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    req_be        = 4'h0;
    resp_ready    = 1'b0;
    r1_req_valid  = 1'b0;
    r1_req_we     = 1'b0;
    r1_req_addr   = 32'h0;
    r1_req_wdata  = 32'h0;
    r1_req_be     = 4'h0;
    r1_resp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk32("rst_resp_rdata", resp_rdata, 32'h0);
    chk1("rst_resp_err", resp_err, 1'b0);
    reset = 1'b0;
    #1;
    chk1("post_rst_req_ready", req_ready, 1'b1);

    // Table-driven transactions
    for (int i = 0; i < 15; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk1($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      chk32($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // Backpressure: hold the response 5 cycles; a request pulse must be ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0010;
    req_be    = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(lat);
    chk32("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk1($sformatf("bp_valid_%0d", i), resp_valid, 1'b1);
      chk32($sformatf("bp_rdata_%0d", i), resp_rdata, 32'hDE22_BE44);
      chk1($sformatf("bp_err_%0d", i), resp_err, 1'b0);
      chk1($sformatf("bp_req_ready_%0d", i), req_ready, 1'b0);
      if (i == 1) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h0000_0000;
        req_be    = 4'b1111;
      end else begin
        req_valid = 1'b0;
        req_we    = 1'b0;
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk1("bp_release_req_ready", req_ready, 1'b1);
    chk1("bp_release_resp_valid", resp_valid, 1'b0);
    repeat (4) @(negedge clk);
    chk1("bp_nothing_queued", resp_valid, 1'b0);
    txn(1'b0, 32'h0000_0010, 32'h0, 4'b1111, rd, er, lat);
    chk32("bp_ignored_store", rd, 32'hDE22_BE44);

    // Reset while a store sits in WAIT with its counter at zero
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'h55AA_55AA;
    req_be    = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk1("wrst_req_ready_in_reset", req_ready, 1'b0);
    chk1("wrst_resp_valid_in_reset", resp_valid, 1'b0);
    reset = 1'b0;
    #1;
    chk1("wrst_req_ready_after", req_ready, 1'b1);
    chk1("wrst_resp_valid_after", resp_valid, 1'b0);
    txn(1'b0, 32'h0000_0020, 32'h0, 4'b1111, rd, er, lat);
    chk32("wrst_store_dropped", rd, 32'h1234_5678);
    chk1("wrst_load_err", er, 1'b0);

    // LATENCY=1 throughput: req_valid held high, resp_ready tied high
    @(negedge clk);
    r1_req_valid = 1'b1;
    r1_req_we    = 1'b1;
    r1_req_be    = 4'b1111;
    last_acc = 0;
    n_acc    = 0;
    n_rv     = 0;
    for (int c = 0; c < 30; c++) begin
      acc = r1_req_ready;
      rv  = r1_resp_valid;
      chk1($sformatf("l1_exclusive_%0d", c), acc && rv, 1'b0);
      if (acc) begin
        if (n_acc > 0) begin
          chk32($sformatf("l1_accept_period_%0d", c), 32'(c - last_acc), 32'd3);
        end
        last_acc = c;
        n_acc++;
      end
      if (rv) begin
        chk32($sformatf("l1_resp_delay_%0d", c), 32'(c - last_acc), 32'd2);
        chk1($sformatf("l1_err_%0d", c), r1_resp_err, 1'b0);
        n_rv++;
      end
      @(negedge clk);
      if (acc) begin
        r1_req_addr  = r1_req_addr + 32'd4;
        r1_req_wdata = r1_req_wdata + 32'd1;
      end
    end
    r1_req_valid = 1'b0;
    chk32("l1_accept_count", 32'(n_acc), 32'd10);
    chk32("l1_resp_count", 32'(n_rv), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
